// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arbState_t;

  // Saturating 16-bit increment used by the optional statistics counters.
  function automatic logic [15:0] satInc16(input logic [15:0] value, input logic inc);
    return (inc && (value != 16'hFFFF)) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/wb_aux_hold_slot.sv
// One-entry holding register for an accepted aux result awaiting a free write-port cycle.
module wb_aux_hold_slot
  import wb_arb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Load,
  input  logic              Clear,
  input  logic              Drain,
  input  logic [ADDR_W-1:0] LoadRegister,
  input  logic [DATA_W-1:0] LoadData,
  output logic              Valid,
  output logic [ADDR_W-1:0] HeldRegister,
  output logic [DATA_W-1:0] HeldData
);

  // Load only happens while empty, so it never coincides with Clear or Drain.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Valid        <= 1'b0;
      HeldRegister <= REG_ZERO;
      HeldData     <= '0;
    end else if (Load) begin
      Valid        <= 1'b1;
      HeldRegister <= LoadRegister;
      HeldData     <= LoadData;
    end else if (Clear || Drain) begin
      Valid        <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, aux results wait in a
// 1-entry slot with bounded starvation. Define WB_ARB_STATS_EN to add saturating statistics outputs.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              PipeRegWrite,
  input  logic [ADDR_W-1:0] PipeWriteRegister,
  input  logic [DATA_W-1:0] PipeWriteData,
  input  logic              AuxValid,
  output logic              AuxReady,
  input  logic [ADDR_W-1:0] AuxWriteRegister,
  input  logic [DATA_W-1:0] AuxWriteData,
  output logic              PipeStall,
  output logic              RFRegWrite,
  output logic [ADDR_W-1:0] RFWriteRegister,
  output logic [DATA_W-1:0] RFWriteData,
  output logic              AuxPending
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       ConflictCount,
  output logic [15:0]       ForceCount,
  output logic [15:0]       KillCount
`endif
);

  arbState_t        stateReg, stateNext;
  logic [CNT_W-1:0] waitCntReg, waitCntNext;
  logic             pipeStallReg;

  logic              slotValid;
  logic [ADDR_W-1:0] slotRegister;
  logic [DATA_W-1:0] slotData;

  logic pipeEffective, auxAccept, auxCollide, slotLoad, slotKill, slotDrain;

  logic              rfWeNext;
  logic [ADDR_W-1:0] rfRegNext;
  logic [DATA_W-1:0] rfDataNext;

  assign pipeEffective = PipeRegWrite && (PipeWriteRegister != REG_ZERO) && !pipeStallReg;
  assign AuxReady      = Reset_n && !slotValid;
  assign auxAccept     = AuxValid && AuxReady;
  // A same-cycle pipe write to the same register is newer in program order and wins.
  assign auxCollide    = pipeEffective && (PipeWriteRegister == AuxWriteRegister);
  assign slotLoad      = auxAccept && (AuxWriteRegister != REG_ZERO) && !auxCollide;

  assign AuxPending = slotValid;
  assign PipeStall  = pipeStallReg;

  wb_aux_hold_slot slot (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Load         (slotLoad),
    .Clear        (slotKill),
    .Drain        (slotDrain),
    .LoadRegister (AuxWriteRegister),
    .LoadData     (AuxWriteData),
    .Valid        (slotValid),
    .HeldRegister (slotRegister),
    .HeldData     (slotData)
  );

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    slotDrain   = 1'b0;
    slotKill    = 1'b0;
    unique case (stateReg)
      IDLE: begin
        waitCntNext = '0;
        if (slotLoad) stateNext = WAIT;
      end
      WAIT: begin
        if (!pipeEffective) begin
          slotDrain   = 1'b1;
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (PipeWriteRegister == slotRegister) begin
          slotKill    = 1'b1;
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (waitCntReg == CNT_W'(MAX_WAIT - 1)) begin
          stateNext   = FORCE;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
        end
      end
      FORCE: begin
        // Pipe is stalled this cycle, so the slot owns the port unconditionally.
        slotDrain   = 1'b1;
        stateNext   = IDLE;
        waitCntNext = '0;
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  always_comb begin
    rfWeNext   = 1'b0;
    rfRegNext  = RFWriteRegister;
    rfDataNext = RFWriteData;
    if (pipeEffective) begin
      rfWeNext   = 1'b1;
      rfRegNext  = PipeWriteRegister;
      rfDataNext = PipeWriteData;
    end else if (slotDrain) begin
      rfWeNext   = 1'b1;
      rfRegNext  = slotRegister;
      rfDataNext = slotData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg        <= IDLE;
      waitCntReg      <= '0;
      pipeStallReg    <= 1'b0;
      RFRegWrite      <= 1'b0;
      RFWriteRegister <= REG_ZERO;
      RFWriteData     <= '0;
    end else begin
      stateReg        <= stateNext;
      waitCntReg      <= waitCntNext;
      pipeStallReg    <= (stateNext == FORCE);
      RFRegWrite      <= rfWeNext;
      RFWriteRegister <= rfRegNext;
      RFWriteData     <= rfDataNext;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic conflictCycle, forceEntry, auxDropped;

  assign conflictCycle = (stateReg == WAIT) && pipeEffective && (PipeWriteRegister != slotRegister);
  assign forceEntry    = (stateReg == WAIT) && (stateNext == FORCE);
  assign auxDropped    = slotKill || (auxAccept && (AuxWriteRegister != REG_ZERO) && auxCollide);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ConflictCount <= '0;
      ForceCount    <= '0;
      KillCount     <= '0;
    end else begin
      ConflictCount <= satInc16(ConflictCount, conflictCycle);
      ForceCount    <= satInc16(ForceCount, forceEntry);
      KillCount     <= satInc16(KillCount, auxDropped);
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int MAX_WAIT = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        PipeRegWrite = 1'b0;
  logic [4:0]  PipeWriteRegister = '0;
  logic [31:0] PipeWriteData = '0;
  logic        AuxValid = 1'b0;
  logic [4:0]  AuxWriteRegister = '0;
  logic [31:0] AuxWriteData = '0;
  logic        AuxReady, PipeStall, RFRegWrite, AuxPending;
  logic [4:0]  RFWriteRegister;
  logic [31:0] RFWriteData;
`ifdef WB_ARB_STATS_EN
  logic [15:0] ConflictCount, ForceCount, KillCount;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .PipeRegWrite      (PipeRegWrite),
    .PipeWriteRegister (PipeWriteRegister),
    .PipeWriteData     (PipeWriteData),
    .AuxValid          (AuxValid),
    .AuxReady          (AuxReady),
    .AuxWriteRegister  (AuxWriteRegister),
    .AuxWriteData      (AuxWriteData),
    .PipeStall         (PipeStall),
    .RFRegWrite        (RFRegWrite),
    .RFWriteRegister   (RFWriteRegister),
    .RFWriteData       (RFWriteData),
    .AuxPending        (AuxPending)
`ifdef WB_ARB_STATS_EN
    ,
    .ConflictCount     (ConflictCount),
    .ForceCount        (ForceCount),
    .KillCount         (KillCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipe wins the port, a held aux result takes any free cycle,
  // the MAX_WAIT-th blocked cycle costs the pipe one stall, a newer pipe write kills it.
  bit          mSlotValid = 0;
  logic [4:0]  mSlotReg = '0;
  logic [31:0] mSlotData = '0;
  int          mBlocked = 0;
  bit          mStall = 0;
  bit          mRfWe = 0;
  logic [4:0]  mRfReg = '0;
  logic [31:0] mRfData = '0;

  always @(posedge Clk or negedge Reset_n) begin : refModel
    bit pipeEff, nValid, nStall, nWe;
    int nBlocked;
    logic [4:0]  nSReg, nRReg;
    logic [31:0] nSData, nRData;
    if (!Reset_n) begin
      mSlotValid <= 0; mSlotReg <= '0; mSlotData <= '0; mBlocked <= 0; mStall <= 0;
      mRfWe <= 0; mRfReg <= '0; mRfData <= '0;
    end else begin
      pipeEff = PipeRegWrite && (PipeWriteRegister != 5'd0) && !mStall;
      nWe = 0; nRReg = mRfReg; nRData = mRfData;
      if (pipeEff) begin
        nWe = 1; nRReg = PipeWriteRegister; nRData = PipeWriteData;
      end else if (mSlotValid) begin
        nWe = 1; nRReg = mSlotReg; nRData = mSlotData;
      end
      nValid = mSlotValid; nSReg = mSlotReg; nSData = mSlotData;
      nBlocked = mBlocked; nStall = 0;
      if (mSlotValid) begin
        if (!pipeEff || PipeWriteRegister == mSlotReg) begin
          nValid = 0; nBlocked = 0;
        end else begin
          nBlocked = mBlocked + 1;
          if (nBlocked == MAX_WAIT) begin nStall = 1; nBlocked = 0; end
        end
      end else if (AuxValid && AuxWriteRegister != 5'd0 &&
                   !(pipeEff && PipeWriteRegister == AuxWriteRegister)) begin
        nValid = 1; nSReg = AuxWriteRegister; nSData = AuxWriteData;
      end
      mSlotValid <= nValid; mSlotReg <= nSReg; mSlotData <= nSData;
      mBlocked <= nBlocked; mStall <= nStall;
      mRfWe <= nWe; mRfReg <= nRReg; mRfData <= nRData;
    end
  end

  // Per-cycle compare of every output against the model.
  always begin
    @(posedge Clk);
    #2;
    if (Reset_n) begin
      check("RFRegWrite", {31'd0, RFRegWrite}, {31'd0, mRfWe});
      check("RFWriteRegister", {27'd0, RFWriteRegister}, {27'd0, mRfReg});
      check("RFWriteData", RFWriteData, mRfData);
      check("PipeStall", {31'd0, PipeStall}, {31'd0, mStall});
      check("AuxPending", {31'd0, AuxPending}, {31'd0, mSlotValid});
      check("AuxReady", {31'd0, AuxReady}, {31'd0, !mSlotValid});
    end
  end

  task automatic nextCycle();
    @(posedge Clk);
    #3;
  endtask

  task automatic pipeIdle();
    PipeRegWrite = 0; PipeWriteRegister = '0; PipeWriteData = '0;
  endtask

  task automatic pulseResetCheck(input string tag);
    #1 Reset_n = 0;
    #1;
    check({tag, "_pending"}, {31'd0, AuxPending}, 32'd0);
    check({tag, "_rfwe"}, {31'd0, RFRegWrite}, 32'd0);
    check({tag, "_ready"}, {31'd0, AuxReady}, 32'd0);
    check({tag, "_stall"}, {31'd0, PipeStall}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_rfwe", {31'd0, RFRegWrite}, 32'd0);
    check("rst_rfreg", {27'd0, RFWriteRegister}, 32'd0);
    check("rst_rfdata", RFWriteData, 32'd0);
    check("rst_ready", {31'd0, AuxReady}, 32'd0);
    nextCycle();
    Reset_n = 1;
    nextCycle();

    // Pipe only, then a write to reg 0 which must not reach the port.
    PipeRegWrite = 1; PipeWriteRegister = 5'd8; PipeWriteData = 32'hDEADBEEF;
    nextCycle();
    check("pipe_we", {31'd0, RFRegWrite}, 32'd1);
    check("pipe_reg", {27'd0, RFWriteRegister}, 32'd8);
    check("pipe_data", RFWriteData, 32'hDEADBEEF);
    PipeWriteRegister = 5'd0; PipeWriteData = 32'h11111111;
    nextCycle();
    check("reg0_we", {31'd0, RFRegWrite}, 32'd0);
    check("reg0_hold", {27'd0, RFWriteRegister}, 32'd8);
    pipeIdle();

    // Aux into an idle port: accepted, pending next cycle, written the cycle after.
    AuxValid = 1; AuxWriteRegister = 5'd9; AuxWriteData = 32'h12345678;
    #1 check("aux_ready_idle", {31'd0, AuxReady}, 32'd1);
    nextCycle();
    AuxValid = 0;
    check("aux_pending", {31'd0, AuxPending}, 32'd1);
    check("aux_not_yet", {31'd0, RFRegWrite}, 32'd0);
    nextCycle();
    check("aux_we", {31'd0, RFRegWrite}, 32'd1);
    check("aux_reg", {27'd0, RFWriteRegister}, 32'd9);
    check("aux_data", RFWriteData, 32'h12345678);
    check("aux_ready_again", {31'd0, AuxReady}, 32'd1);

    // Starvation: pipe writes reg 5 every cycle while aux reg 10 waits.
    PipeRegWrite = 1; PipeWriteRegister = 5'd5; PipeWriteData = 32'h00000055;
    AuxValid = 1; AuxWriteRegister = 5'd10; AuxWriteData = 32'hA0A0A0A0;
    nextCycle();
    AuxValid = 0;
    check("starve_pending", {31'd0, AuxPending}, 32'd1);
    for (int i = 0; i < MAX_WAIT; i++) begin
      nextCycle();
      check("starve_stall", {31'd0, PipeStall}, {31'd0, (i == MAX_WAIT - 1)});
    end
    nextCycle();
    check("force_reg", {27'd0, RFWriteRegister}, 32'd10);
    check("force_data", RFWriteData, 32'hA0A0A0A0);
    check("force_unstall", {31'd0, PipeStall}, 32'd0);
    nextCycle();
    check("replay_reg", {27'd0, RFWriteRegister}, 32'd5);
    pipeIdle();
    nextCycle();

    // Kill: newer pipe write to the held register drops the aux result.
    AuxValid = 1; AuxWriteRegister = 5'd7; AuxWriteData = 32'h77777777;
    nextCycle();
    AuxValid = 0;
    PipeRegWrite = 1; PipeWriteRegister = 5'd7; PipeWriteData = 32'hAAAA0000;
    nextCycle();
    check("kill_data", RFWriteData, 32'hAAAA0000);
    check("kill_cleared", {31'd0, AuxPending}, 32'd0);
    pipeIdle();
    nextCycle();
    check("kill_no_aux", {31'd0, RFRegWrite}, 32'd0);
`ifdef WB_ARB_STATS_EN
    check("kill_count", {16'd0, KillCount}, 32'd1);
`endif

    // Backpressure: second offer waits until the slot drains.
    AuxValid = 1; AuxWriteRegister = 5'd11; AuxWriteData = 32'hB1B1B1B1;
    nextCycle();
    AuxWriteRegister = 5'd12; AuxWriteData = 32'hC2C2C2C2;
    check("bp_not_ready", {31'd0, AuxReady}, 32'd0);
    nextCycle();
    check("bp_first_reg", {27'd0, RFWriteRegister}, 32'd11);
    check("bp_ready", {31'd0, AuxReady}, 32'd1);
    nextCycle();
    AuxValid = 0;
    nextCycle();
    check("bp_second_reg", {27'd0, RFWriteRegister}, 32'd12);
    check("bp_second_data", RFWriteData, 32'hC2C2C2C2);
    nextCycle();
    check("bp_no_dup", {31'd0, RFRegWrite}, 32'd0);

    // Reset mid-WAIT.
    AuxValid = 1; AuxWriteRegister = 5'd13; AuxWriteData = 32'hBADC0DE5;
    nextCycle();
    AuxValid = 0;
    PipeRegWrite = 1; PipeWriteRegister = 5'd4; PipeWriteData = 32'h44;
    nextCycle();
    pulseResetCheck("midwait");
    pipeIdle();
    nextCycle();
    Reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      check("post_rst_nowrite", {31'd0, RFRegWrite}, 32'd0);
    end

    // Randomized traffic, pipe contents held while the model says the pipe is stalled.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulseResetCheck("rand_rst");
        nextCycle();
        Reset_n = 1;
      end
      if (!mStall) begin
        PipeRegWrite      = ($urandom_range(0, 9) < 6);
        PipeWriteRegister = 5'($urandom_range(0, 7));
        PipeWriteData     = $urandom;
      end
      AuxValid         = ($urandom_range(0, 1) == 1);
      AuxWriteRegister = 5'($urandom_range(0, 7));
      AuxWriteData     = $urandom;
      nextCycle();
    end

    pipeIdle();
    AuxValid = 0;
    nextCycle();
    nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
